// File: rtl/display_mux_scheduler.sv
// Two-digit multiplexed seven-segment scan scheduler; define DMS_BLANK_EN to add dead-time states between digits.
// Latency: hex_out/seg_power/frame_tick are registered and change one edge after the state decision.
// Backpressure: none; en=0 freezes state and count and blanks both digits until en returns.
module display_mux_scheduler #(
    parameter int HOLD_CYCLES  = 24000,
    parameter int BLANK_CYCLES = 240
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] s1,
    input  logic [3:0] s2,
    output logic [3:0] hex_out,
    output logic [1:0] seg_power,
    output logic       frame_tick
);

    localparam int CNT_MAX = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
`ifdef DMS_BLANK_EN
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHOW0  = 3'd1,
        SHOW1  = 3'd2
`ifdef DMS_BLANK_EN
        ,
        BLANK0 = 3'd3,
        BLANK1 = 3'd4
`endif
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [3:0]    hex_nxt;
    logic [1:0]    seg_nxt;
    logic          tick_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hex_nxt   = hex_out;
        seg_nxt   = 2'b11;
        tick_nxt  = 1'b0;

        if (en) begin
            case (state)
                IDLE: state_nxt = SHOW0;
                SHOW0: begin
                    if (cnt == HOLD_LAST) begin
`ifdef DMS_BLANK_EN
                        state_nxt = BLANK0;
`else
                        state_nxt = SHOW1;
`endif
                    end
                end
`ifdef DMS_BLANK_EN
                BLANK0: begin
                    if (cnt == BLANK_LAST) state_nxt = SHOW1;
                end
                SHOW1: begin
                    if (cnt == HOLD_LAST) state_nxt = BLANK1;
                end
                BLANK1: begin
                    if (cnt == BLANK_LAST) begin
                        state_nxt = SHOW0;
                        tick_nxt  = 1'b1;
                    end
                end
`else
                SHOW1: begin
                    if (cnt == HOLD_LAST) begin
                        state_nxt = SHOW0;
                        tick_nxt  = 1'b1;
                    end
                end
`endif
                default: state_nxt = IDLE;
            endcase

            // Terminal compare wins over increment, so the counter never wraps.
            if (state_nxt != state) begin
                cnt_nxt = '0;
                if (state_nxt == SHOW0) hex_nxt = s1;
                if (state_nxt == SHOW1) hex_nxt = s2;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end

            // Resuming after an en gap restores the digit enable without re-latching the value.
            case (state_nxt)
                SHOW0:   seg_nxt = 2'b10;
                SHOW1:   seg_nxt = 2'b01;
                default: seg_nxt = 2'b11;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            hex_out    <= 4'h0;
            seg_power  <= 2'b11;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            hex_out    <= hex_nxt;
            seg_power  <= seg_nxt;
            frame_tick <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_display_mux_scheduler.sv
// Scoreboard bench for display_mux_scheduler with HOLD_CYCLES=4, BLANK_CYCLES=2.
module tb_display_mux_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] hex_out;
    logic [1:0] seg_power;
    logic       frame_tick;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int         cyc;
        logic [1:0] seg;
        logic [3:0] hex;
        logic       tick;
    } exp_t;

    exp_t sb[$];

`ifdef DMS_BLANK_EN
    localparam int FRAME    = 12;
    localparam int S1_START = 6;
`else
    localparam int FRAME    = 8;
    localparam int S1_START = 4;
`endif

    display_mux_scheduler #(
        .HOLD_CYCLES (4),
        .BLANK_CYCLES(2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .s1        (s1),
        .s2        (s2),
        .hex_out   (hex_out),
        .seg_power (seg_power),
        .frame_tick(frame_tick)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, required %h", nm, cyc, act, req);
    endtask

    // Hand-derived frame pattern: digit 0 for 4 cycles, optional 2 dark, digit 1 for 4, optional 2 dark.
    function automatic logic [1:0] pat_seg(input int i);
`ifdef DMS_BLANK_EN
        if (i < 4) return 2'b10;
        if (i < 6) return 2'b11;
        if (i < 10) return 2'b01;
        return 2'b11;
`else
        return (i < 4) ? 2'b10 : 2'b01;
`endif
    endfunction

    function automatic logic [3:0] pat_hex(input int i, input logic [3:0] a, input logic [3:0] b);
        return (i < S1_START) ? a : b;
    endfunction

    task automatic step(input logic e, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] xs, input logic [3:0] xh, input logic xt);
        exp_t x;
        en = e;
        s1 = a;
        s2 = b;
        x.cyc  = cyc + 1;
        x.seg  = xs;
        x.hex  = xh;
        x.tick = xt;
        sb.push_back(x);
        @(posedge clock);
        #1;
    endtask

    task automatic frame_step(input int i, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] ha, input logic [3:0] hb, input logic t);
        step(1'b1, a, b, pat_seg(i), pat_hex(i, ha, hb), t);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset === 1'b1) begin
            n_checks++;
            if (seg_power !== 2'b00) n_pass++;
            else $display("FAIL both_digits_on at cycle %0d: got 00, required not 00", cyc);
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc != cyc) begin
                n_checks++;
                $display("FAIL sb_stale: expectation for cycle %0d, required at cycle %0d", e.cyc, cyc);
            end else begin
                check("seg_power", {2'b00, seg_power}, {2'b00, e.seg});
                check("hex_out", hex_out, e.hex);
                check("frame_tick", {3'b000, frame_tick}, {3'b000, e.tick});
            end
        end
    end

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        s1    = 4'h5;
        s2    = 4'hA;
        repeat (2) @(posedge clock);
        #1;
        check("rst_seg", {2'b00, seg_power}, 4'b0011);
        check("rst_hex", hex_out, 4'h0);
        check("rst_tick", {3'b000, frame_tick}, 4'b0000);
        reset = 1'b1;

        // Idle with scanning disabled.
        step(1'b0, 4'h5, 4'hA, 2'b11, 4'h0, 1'b0);
        step(1'b0, 4'h5, 4'hA, 2'b11, 4'h0, 1'b0);

        // Three steady frames; tick appears at the start of each frame after the first.
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < FRAME; i++)
                frame_step(i, 4'h5, 4'hA, 4'h5, 4'hA, (f > 0 && i == 0));

        // en gap after two lit cycles of digit 1.
        for (int i = 0; i < S1_START + 2; i++)
            frame_step(i, 4'h5, 4'hA, 4'h5, 4'hA, (i == 0));
        repeat (5) step(1'b0, 4'h5, 4'hA, 2'b11, 4'hA, 1'b0);
        repeat (2) step(1'b1, 4'h5, 4'hA, 2'b01, 4'hA, 1'b0);
        for (int i = S1_START + 4; i < FRAME; i++)
            frame_step(i, 4'h5, 4'hA, 4'h5, 4'hA, 1'b0);

        // Asynchronous reset in the middle of digit 1.
        for (int i = 0; i < S1_START + 2; i++)
            frame_step(i, 4'h5, 4'hA, 4'h5, 4'hA, (i == 0));
        @(negedge clock);
        #1;
        reset = 1'b0;
        s1    = 4'h0;
        #1;
        check("async_rst_seg", {2'b00, seg_power}, 4'b0011);
        check("async_rst_hex", hex_out, 4'h0);
        check("async_rst_tick", {3'b000, frame_tick}, 4'b0000);
        #1;
        reset = 1'b1;

        // Restart captures current s1 (0); a change to F mid-phase shows only on the next entry.
        step(1'b1, 4'h0, 4'hA, 2'b10, 4'h0, 1'b0);
        step(1'b1, 4'h0, 4'hA, 2'b10, 4'h0, 1'b0);
        step(1'b1, 4'hF, 4'hA, 2'b10, 4'h0, 1'b0);
        step(1'b1, 4'hF, 4'hA, 2'b10, 4'h0, 1'b0);
        for (int i = 4; i < FRAME; i++)
            frame_step(i, 4'hF, 4'hA, 4'h0, 4'hA, 1'b0);
        for (int i = 0; i < 4; i++)
            frame_step(i, 4'hF, 4'hA, 4'hF, 4'hA, (i == 0));

        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL sb_drained: %0d expectations left, required 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display_mux_scheduler.md
DISPLAY_MUX_SCHEDULER -- requirements
Module: display_mux_scheduler

Interface
REQ-001 Parameter HOLD_CYCLES, default 24000: clock cycles each digit is lit per phase; legal range 2..2^20.
REQ-002 Parameter BLANK_CYCLES, default 240: dead-time cycles between digits; legal range 1..2^16; used only when DMS_BLANK_EN is defined.
REQ-003 Port clock  input  1: single system clock; all flops on rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port en  input  1: scan enable; 0 freezes the scheduler and blanks the display.
REQ-006 Port s1  input  4: hex value for digit 0.
REQ-007 Port s2  input  4: hex value for digit 1.
REQ-008 Port hex_out  output  4: value presented to the shared seven-segment decoder.
REQ-009 Port seg_power  output  2: active-low digit enables; bit0 = digit 0, bit1 = digit 1.
REQ-010 Port frame_tick  output  1: one-cycle pulse marking completion of a full two-digit frame.

Function
REQ-011 The block SHALL implement states IDLE, SHOW0, BLANK0, SHOW1, BLANK1 plus one shared phase counter sized to max(HOLD_CYCLES, BLANK_CYCLES).
REQ-012 The block SHALL drive hex_out, seg_power and frame_tick directly from flops, with no combinational path from inputs.
REQ-013 IDLE: the block SHALL hold seg_power=2'b11 and hex_out=4'h0; on the first clock edge with en=1, it SHALL go to SHOW0.
REQ-014 On every edge entering SHOW0 (resp. SHOW1), the block SHALL capture s1 (resp. s2) into hex_out and set seg_power=2'b10 (resp. 2'b01) on that same edge.
REQ-015 The block SHALL ignore s1/s2 changes within a SHOW phase until that state is next entered.
REQ-016 The counter SHALL clear on every state entry and increment each enabled cycle.
REQ-017 A SHOW state SHALL exit when count = HOLD_CYCLES-1, giving exactly HOLD_CYCLES lit cycles.
REQ-018 A BLANK state SHALL exit when count = BLANK_CYCLES-1 and SHALL hold seg_power=2'b11 and hex_out unchanged.
REQ-019 The state sequence SHALL be SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0 (blanking config).
REQ-020 The block SHALL assert frame_tick for exactly the one cycle after the edge on which SHOW1 (or BLANK1 when present) exits.
REQ-021 At most one seg_power bit SHALL be 0 in any cycle.
REQ-022 en=0: state and counter SHALL hold, seg_power SHALL be forced to 2'b11 on the next edge, and frame_tick SHALL be 0.
REQ-023 When en returns to 1, the interrupted state SHALL resume with its remaining count; its seg_power value SHALL be restored on that edge without re-latching the digit.
REQ-024 Counter wrap SHALL never occur; terminal-count compare takes priority over increment.

Reset
REQ-025 reset=0 SHALL immediately force state=IDLE, counter=0, hex_out=4'h0, seg_power=2'b11 and frame_tick=0, independent of clock.
REQ-026 Reset asserted mid-phase SHALL abandon the frame; after release, scanning SHALL restart at SHOW0 with a fresh s1 capture.

Configuration
REQ-027 With macro DMS_BLANK_EN defined, BLANK0/BLANK1 SHALL be compiled in and BLANK_CYCLES SHALL be honored.
REQ-028 Without DMS_BLANK_EN, BLANK states SHALL be absent, the sequence SHALL be SHOW0 -> SHOW1 -> SHOW0, BLANK_CYCLES SHALL be unused, and frame_tick SHALL follow the SHOW1 exit.

Verification (HOLD_CYCLES=4, BLANK_CYCLES=2)
REQ-029 DMS_BLANK_EN on, en=1, s1=4'h5, s2=4'hA, reset released -> repeating 12-cycle pattern: seg_power 2'b10 x4 with hex_out=5, 2'b11 x2, 2'b01 x4 with hex_out=A, 2'b11 x2; frame_tick high once per 12 cycles.
REQ-030 DMS_BLANK_EN off, same stimulus -> 8-cycle pattern 2'b10 x4 / 2'b01 x4, never 2'b11 after the first SHOW0, frame_tick once per 8 cycles.
REQ-031 s1 changes 4'h0 -> 4'hF on the 2nd cycle of SHOW0 -> hex_out stays 0 for that phase and reads F on the next SHOW0 entry.
REQ-032 en dropped for 5 cycles after 2 cycles of SHOW1 -> seg_power=2'b11 during the gap, then 2'b01 for exactly 2 more cycles, with no frame_tick during the gap.
REQ-033 reset pulsed low mid-SHOW1 -> outputs immediately become 2'b11 / 4'h0 / 0; first edge after release enters SHOW0 and captures the current s1.
REQ-034 A checker on all scenarios SHALL never observe seg_power=2'b00.
